cap_sense_scanner: RTL and testbench



---
 rtl/cap_sense_pkg.sv | 19 +
 rtl/cap_sense_channel.sv | 105 ++++++++++
 rtl/cap_sense_scanner.sv | 110 +++++++++++
 tb/tb_cap_sense_scanner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cap_sense_pkg.sv
// Shared constants, FSM encoding and parameter defaults for the capacitive
// touch scanner.
package cap_sense_pkg;

  localparam int unsigned NUM_SENSORS = 9;

  localparam int unsigned DefDischargeCycles = 1000;
  localparam int unsigned DefTimeoutCycles   = 4095;
  localparam int unsigned DefThreshold       = 200;
  localparam int unsigned DefDebounceScans   = 3;
  localparam int unsigned DefCntW            = 12;

  typedef enum logic [1:0] {
    StDischarge,
    StCharge,
    StEvaluate
  } state_e;

endpackage

// File: rtl/cap_sense_channel.sv
// One pad: input synchronizer, charge-time capture, threshold, debounce and
// sticky hit flag.
module cap_sense_channel
  import cap_sense_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned THRESHOLD      = DefThreshold,
  parameter int unsigned DEBOUNCE_SCANS = DefDebounceScans,
  parameter int unsigned CNT_W          = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sens_i,
  input  logic             hit_clear_i,
  input  logic             discharge_i,
  input  logic             charge_i,
  input  logic             evaluate_i,
  input  logic             timeout_i,
  input  logic [CNT_W-1:0] charge_cnt_i,
  output logic             latched_o,
  output logic             stable_o,
  output logic             hit_pending_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_SCANS + 1);

  logic             sync1_q, sens_s_q;
  logic             latched_q, latched_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DbW-1:0]   db_q, db_d;
  logic [DbW-1:0]   db_inc;
  logic             stable_q, stable_d;
  logic             hit_q, hit_d;
  logic             latch_now;
  logic             raw;

  assign latch_now = charge_i & sens_s_q & ~latched_q;
  assign raw       = (count_q >= CNT_W'(THRESHOLD));
  // db_q never exceeds DEBOUNCE_SCANS-1, so the increment cannot overflow DbW.
  assign db_inc    = db_q + 1'b1;

  always_comb begin
    latched_d = latched_q;
    count_d   = count_q;
    db_d      = db_q;
    stable_d  = stable_q;

    if (discharge_i) begin
      latched_d = 1'b0;
    end else if (charge_i) begin
      if (latch_now) begin
        latched_d = 1'b1;
        count_d   = charge_cnt_i;
      end else if (timeout_i && !latched_q) begin
        count_d = CNT_W'(TIMEOUT_CYCLES);
      end
    end else if (evaluate_i) begin
      if (raw != stable_q) begin
        if (db_inc == DbW'(DEBOUNCE_SCANS)) begin
          stable_d = ~stable_q;
          db_d     = '0;
        end else begin
          db_d = db_inc;
        end
      end else begin
        db_d = '0;
      end
    end

    // A debounced rise beats a same-cycle clear.
    if (stable_d && !stable_q) begin
      hit_d = 1'b1;
    end else if (hit_clear_i) begin
      hit_d = 1'b0;
    end else begin
      hit_d = hit_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sens_s_q  <= 1'b0;
      latched_q <= 1'b0;
      count_q   <= '0;
      db_q      <= '0;
      stable_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      sync1_q   <= sens_i;
      sens_s_q  <= sync1_q;
      latched_q <= latched_d;
      count_q   <= count_d;
      db_q      <= db_d;
      stable_q  <= stable_d;
      hit_q     <= hit_d;
    end
  end

  // Includes a pad latching this cycle so the FSM can leave CHARGE immediately.
  assign latched_o     = latched_q | latch_now;
  assign stable_o      = stable_q;
  assign hit_pending_o = hit_q;

endmodule

// File: rtl/cap_sense_scanner.sv
// Scan sequencer: discharge / charge / evaluate FSM with shared counters,
// driving nine pad channels.
module cap_sense_scanner
  import cap_sense_pkg::*;
#(
  parameter int unsigned DISCHARGE_CYCLES = DefDischargeCycles,
  parameter int unsigned TIMEOUT_CYCLES   = DefTimeoutCycles,
  parameter int unsigned THRESHOLD        = DefThreshold,
  parameter int unsigned DEBOUNCE_SCANS   = DefDebounceScans,
  parameter int unsigned CNT_W            = DefCntW
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  input  logic [NUM_SENSORS-1:0] hit_clear,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touch_stable,
  output logic [NUM_SENSORS-1:0] hit_pending,
  output logic                   scan_done
);

  localparam int unsigned PhW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [PhW-1:0]         phase_q, phase_d;
  logic [CNT_W-1:0]       charge_cnt_q, charge_cnt_d;
  logic                   out_q, out_d;
  logic                   done_q, done_d;
  logic [NUM_SENSORS-1:0] latched;
  logic                   in_discharge, in_charge, in_evaluate;
  logic                   charge_timeout;

  assign in_discharge   = (state_q == StDischarge);
  assign in_charge      = (state_q == StCharge);
  assign in_evaluate    = (state_q == StEvaluate);
  assign charge_timeout = in_charge && (charge_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    charge_cnt_d = charge_cnt_q;

    unique case (state_q)
      StDischarge: begin
        if (phase_q == PhW'(DISCHARGE_CYCLES - 1)) begin
          phase_d = '0;
          state_d = StCharge;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StCharge: begin
        // Leaving at TIMEOUT_CYCLES-1 keeps the counter from ever wrapping.
        if ((&latched) || charge_timeout) begin
          charge_cnt_d = '0;
          state_d      = StEvaluate;
        end else begin
          charge_cnt_d = charge_cnt_q + 1'b1;
        end
      end
      StEvaluate: state_d = StDischarge;
      default:    state_d = StDischarge;
    endcase

    out_d  = (state_d == StCharge);
    done_d = (state_d == StEvaluate);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StDischarge;
      phase_q      <= '0;
      charge_cnt_q <= '0;
      out_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      charge_cnt_q <= charge_cnt_d;
      out_q        <= out_d;
      done_q       <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
    cap_sense_channel #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .THRESHOLD     (THRESHOLD),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk_i        (clock),
      .rst_i        (reset),
      .sens_i       (capacitive_sensors_in[g]),
      .hit_clear_i  (hit_clear[g]),
      .discharge_i  (in_discharge),
      .charge_i     (in_charge),
      .evaluate_i   (in_evaluate),
      .timeout_i    (charge_timeout),
      .charge_cnt_i (charge_cnt_q),
      .latched_o    (latched[g]),
      .stable_o     (touch_stable[g]),
      .hit_pending_o(hit_pending[g])
    );
  end

  assign capacitive_sensors_out = out_q;
  assign scan_done              = done_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Bench for cap_sense_scanner: directed scenarios plus random pad timings and
// clears, compared every cycle against a scan-level behavioural model.
module tb_cap_sense_scanner;

  localparam int DIS = 4;
  localparam int TO  = 63;
  localparam int TH  = 20;
  localparam int DB  = 2;
  localparam int NEVER = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] sens_in = '0;
  logic [8:0] hit_clear = '0;
  logic       sens_out;
  logic [8:0] touch_stable, hit_pending;
  logic       scan_done;

  int checks = 0;
  int errors = 0;

  cap_sense_scanner #(
    .DISCHARGE_CYCLES(DIS),
    .TIMEOUT_CYCLES  (TO),
    .THRESHOLD       (TH),
    .DEBOUNCE_SCANS  (DB),
    .CNT_W           (12)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .capacitive_sensors_in (sens_in),
    .hit_clear             (hit_clear),
    .capacitive_sensors_out(sens_out),
    .touch_stable          (touch_stable),
    .hit_pending           (hit_pending),
    .scan_done             (scan_done)
  );

  always #5 clock = ~clock;

  // Model: per scan, each pad rises r cycles into charge (seen 2 cycles later).
  int         next_r[9];
  int         m_r[9];
  int         m_c[9];
  int         m_streak[9];
  int         m_t = 0;
  int         m_clen = TO;
  logic [8:0] m_stable = '0, m_hit = '0;
  logic       m_out = 1'b0, m_done = 1'b0, m_valid = 1'b0;

  function automatic void load_scan();
    int mx = 0;
    bit all_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      m_r[i] = next_r[i];
      if (m_r[i] + 2 <= TO - 1) begin
        m_c[i] = m_r[i] + 2;
        if (m_c[i] > mx) mx = m_c[i];
      end else begin
        m_c[i] = TO;
        all_in = 1'b0;
      end
    end
    m_clen = all_in ? mx + 1 : TO;
  endfunction

  initial begin
    logic [8:0] rise;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_t = 0;
        m_stable = '0;
        m_hit = '0;
        for (int i = 0; i < 9; i++) m_streak[i] = 0;
        load_scan();
        m_valid = 1'b1;
      end else begin
        rise = '0;
        if (m_t == DIS + m_clen) begin
          for (int i = 0; i < 9; i++) begin
            if ((m_c[i] >= TH) != m_stable[i]) begin
              m_streak[i]++;
              if (m_streak[i] >= DB) begin
                m_stable[i] = ~m_stable[i];
                m_streak[i] = 0;
                rise[i] = m_stable[i];
              end
            end else begin
              m_streak[i] = 0;
            end
          end
          m_t = 0;
        end else begin
          m_t++;
        end
        for (int i = 0; i < 9; i++) begin
          if (rise[i]) m_hit[i] = 1'b1;
          else if (hit_clear[i]) m_hit[i] = 1'b0;
        end
        if (m_t == 0) load_scan();
      end
      m_out  = (m_t >= DIS) && (m_t < DIS + m_clen);
      m_done = (m_t == DIS + m_clen);
    end
  end

  // Pad emulation: input rises r cycles after the model's charge phase begins.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 9; i++) sens_in[i] = m_out && ((m_t - DIS) >= m_r[i]);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        checks++;
        if ({sens_out, scan_done, touch_stable, hit_pending} !==
            {m_out, m_done, m_stable, m_hit}) begin
          errors++;
          $display("FAIL cycle_compare t=%0t: got out=%b done=%b stable=%h hit=%h, want out=%b done=%b stable=%h hit=%h",
                   $time, sens_out, scan_done, touch_stable, hit_pending,
                   m_out, m_done, m_stable, m_hit);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic next_scan(output int period);
    period = 0;
    do begin
      @(negedge clock);
      period++;
    end while (scan_done !== 1'b1 && period < 200);
    check("scan_done_seen", {31'd0, scan_done}, 32'd1);
  endtask

  task automatic set_all_r(input int v);
    for (int i = 0; i < 9; i++) next_r[i] = v;
  endtask

  initial begin
    int p;
    int w;
    set_all_r(5);
    repeat (3) @(negedge clock);
    check("reset_outputs", {sens_out, scan_done, touch_stable, hit_pending}, 0);
    reset = 1'b0;

    // All pads at 5: counts 7, period 4+8+1.
    next_scan(p); check("first_period", p, 12);
    next_scan(p); check("period_13", p, 13);
    check("stable_untouched", touch_stable, 0);

    // Pad 3 slow: needs two scans.
    next_r[3] = 28;
    next_scan(p); check("pad3_period", p, 36);
    @(negedge clock); check("pad3_after_1", touch_stable, 0);
    next_scan(p);
    @(negedge clock);
    check("pad3_stable", touch_stable, 9'h008);
    check("pad3_hit", hit_pending, 9'h008);
    hit_clear[3] = 1'b1;
    @(negedge clock);
    hit_clear = '0;
    check("pad3_clear", hit_pending, 0);
    next_scan(p);

    // Pad 8 never rises: timeout charge.
    set_all_r(5); next_r[8] = NEVER;
    next_scan(p); check("timeout_period", p, 68);
    @(negedge clock); check("pad8_after_1", touch_stable[8], 0);
    next_scan(p);
    @(negedge clock);
    check("pad8_stable", touch_stable[8], 1);
    check("pad8_hit", hit_pending[8], 1);
    hit_clear[8] = 1'b1;
    @(negedge clock);
    hit_clear = '0;
    check("pad8_clear", hit_pending[8], 0);
    next_scan(p);

    // Pad 0 alternates each scan: never debounces.
    set_all_r(5);
    for (int k = 0; k < 6; k++) begin
      next_r[0] = (k % 2 == 0) ? 28 : 5;
      next_scan(p);
    end
    @(negedge clock);
    check("pad0_stable", touch_stable[0], 0);
    check("pad0_hit", hit_pending[0], 0);
    next_scan(p);

    // Clear coincident with pad 5's debounced rise: set wins.
    set_all_r(5); next_r[5] = 28;
    next_scan(p);
    next_scan(p);
    hit_clear[5] = 1'b1;
    @(negedge clock);
    hit_clear = '0;
    check("pad5_set_wins", hit_pending[5], 1);
    check("pad5_stable", touch_stable[5], 1);
    next_scan(p);

    // Reset mid-charge with pad 2 touched.
    next_r[2] = 28;
    next_scan(p);
    next_scan(p);
    set_all_r(5);
    w = 0;
    while (m_t != DIS + 3 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("reached_charge", {31'd0, m_out}, 1);
    check("pad2_stable", touch_stable[2], 1);
    reset = 1'b1;
    @(negedge clock);
    check("midscan_reset", {sens_out, scan_done, touch_stable, hit_pending}, 0);
    reset = 1'b0;
    next_scan(p); check("restart_period", p, 12);

    // Random pad timings and clear pulses.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      hit_clear = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'h000;
      if (m_done) begin
        for (int i = 0; i < 9; i++) begin
          w = $urandom_range(0, 9);
          if (w == 0) next_r[i] = NEVER;
          else if (w < 5) next_r[i] = $urandom_range(0, 15);
          else next_r[i] = $urandom_range(16, 40);
        end
      end
    end
    hit_clear = '0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
